lsu: RTL and testbench

Load/store unit for the MEM stage of the 5-stage RV32I pipeline. It accepts the memory operation that EX produced: the effective address from the ALU result, the forwarded rs2 store data, and funct3. It drives a req/gnt/rvalid data-memory bus, aligns and extends load data, and stalls the pipeline until the access completes. At most one access is outstanding.

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/lsu_load_align.sv | 24 ++
 rtl/lsu.sv | 143 ++++++++++++++
 tb/tb_lsu.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants, LSU state type and decode helpers
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b01:   return !off[0];
      2'b10:   return off == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/halfword of a read word and extends it
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0]     rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  data = {24'b0, shifted[7:0]};
      F3_LHU:  data = {16'b0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - MEM-stage load/store unit: one outstanding req/gnt/rvalid access, stalls until done
module lsu
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            lsu_stall,
  output logic            load_valid,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned_exc,
  output logic [XLEN-1:0] exc_addr,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [31:0]     dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [31:0]     dmem_rdata
);

  lsu_state_t      state_q, state_d;
  logic            req_q, req_d, we_q, we_d, load_valid_q, load_valid_d;
  logic [XLEN-1:0] addr_q, addr_d, load_data_q, load_data_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;

  logic            decoded, aligned, launch;
  logic [3:0]      be_calc;
  logic [31:0]     wdata_calc;
  logic [XLEN-1:0] aligned_word;

  lsu_load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (aligned_word)
  );

  // Decode depends only on the pipeline inputs and state, never on the bus handshake
  always_comb begin
    decoded = mem_valid && (mem_read ^ mem_write) &&
              (mem_read ? load_f3_legal(funct3) : store_f3_legal(funct3));
    aligned = addr_aligned(funct3[1:0], addr[1:0]);
    launch  = (state_q == IDLE) && decoded && aligned;

    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << addr[1:0];
        wdata_calc = {2{store_data[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = store_data;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    off_d        = off_q;
    f3_d         = f3_q;
    load_valid_d = 1'b0;
    load_data_d  = load_data_q;
    case (state_q)
      IDLE: if (launch) begin
        state_d = REQ;
        req_d   = 1'b1;
        we_d    = mem_write;
        addr_d  = {addr[XLEN-1:2], 2'b00};
        be_d    = be_calc;
        wdata_d = mem_write ? wdata_calc : 32'b0;
        off_d   = addr[1:0];
        f3_d    = funct3;
      end
      REQ: if (dmem_gnt) begin
        req_d   = 1'b0;
        state_d = we_q ? DONE : WAIT;
      end
      WAIT: if (dmem_rvalid) begin
        load_data_d  = aligned_word;
        load_valid_d = 1'b1;
        state_d      = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      off_q        <= '0;
      f3_q         <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
    end
  end

  assign lsu_stall      = launch || (state_q == REQ) || (state_q == WAIT);
  assign misaligned_exc = (state_q == IDLE) && decoded && !aligned;
  assign exc_addr       = misaligned_exc ? addr : '0;
  assign load_valid     = load_valid_q;
  assign load_data      = load_data_q;
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = '0, store_data = '0;
  logic        lsu_stall, load_valid, misaligned_exc;
  logic [31:0] load_data, exc_addr;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .lsu_stall(lsu_stall),
    .load_valid(load_valid), .load_data(load_data), .misaligned_exc(misaligned_exc),
    .exc_addr(exc_addr), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  // Acts as pipeline + memory slave for one access; called at posedge+1 of the launch cycle
  task automatic run_access(input logic rd, input logic [2:0] f3, input logic [31:0] a,
      input logic [31:0] sd, input int gnt_wait, input logic [31:0] rdata,
      output int stalls, output logic launched, output logic lv, output logic [31:0] ld,
      output logic [31:0] req_addr, output logic [3:0] req_be, output logic [31:0] req_wdata,
      output logic req_we, output logic stable, output int lv_cycle);
    int c = 0;
    int req_cycles = 0;
    logic done = 1'b0;
    stalls = 0; launched = 1'b0; lv = 1'b0; ld = '0; req_addr = '0; req_be = '0;
    req_wdata = '0; req_we = 1'b0; stable = 1'b1; lv_cycle = -1;
    mem_valid = 1'b1; mem_read = rd; mem_write = !rd; funct3 = f3; addr = a; store_data = sd;
    while (!done && c < 40) begin
      @(negedge clk);
      if (lsu_stall) stalls++;
      if (c == 0) launched = lsu_stall;
      if (dmem_req) begin
        if (req_cycles == 0) begin
          req_addr = dmem_addr; req_be = dmem_be; req_wdata = dmem_wdata; req_we = dmem_we;
        end else if (dmem_addr !== req_addr || dmem_be !== req_be ||
                     dmem_wdata !== req_wdata || dmem_we !== req_we) begin
          stable = 1'b0;
        end
        req_cycles++;
        if (req_cycles > gnt_wait) dmem_gnt = 1'b1;
      end else if (lsu_stall && c > 0) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
      end
      if (load_valid) begin
        lv = 1'b1; ld = load_data; lv_cycle = c;
      end
      if (c > 0 && !lsu_stall) done = 1'b1;
      @(posedge clk); #1;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      c++;
    end
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout addr=%h got no DONE within 40 cycles", a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({lsu_stall, load_valid, misaligned_exc, dmem_req, dmem_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000",
               {lsu_stall, load_valid, misaligned_exc, dmem_req, dmem_we});
    end
    checks++;
    if ({load_data, exc_addr, dmem_addr, dmem_wdata, dmem_be} !== 132'b0) begin
      errors++;
      $display("FAIL reset_data got ld=%h ea=%h da=%h wd=%h be=%b want all zero",
               load_data, exc_addr, dmem_addr, dmem_wdata, dmem_be);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_lw();
    int st, lvc; logic la, lv, we, stb; logic [31:0] ld, ra, wd; logic [3:0] be;
    run_access(1'b1, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, st, la, lv, ld, ra, be, wd, we, stb, lvc);
    checks++;
    if (ra !== 32'h100 || be !== 4'b1111 || we !== 1'b0) begin
      errors++;
      $display("FAIL lw_bus got addr=%h be=%b we=%b want 00000100 1111 0", ra, be, we);
    end
    checks++;
    if (lv !== 1'b1 || ld !== 32'hDEADBEEF || lvc != 3) begin
      errors++;
      $display("FAIL lw_data got lv=%b data=%h cycle=%0d want 1 deadbeef 3", lv, ld, lvc);
    end
    checks++;
    if (st != 3) begin
      errors++;
      $display("FAIL lw_stall got %0d want 3", st);
    end
  endtask

  task automatic test_lb_lbu();
    int st, lvc; logic la, lv, we, stb; logic [31:0] ld, ra, wd; logic [3:0] be;
    run_access(1'b1, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_0000, st, la, lv, ld, ra, be, wd, we, stb, lvc);
    checks++;
    if (ld !== 32'hFFFFFF80 || ra !== 32'h100 || be !== 4'b1000) begin
      errors++;
      $display("FAIL lb_signext got data=%h addr=%h be=%b want ffffff80 00000100 1000", ld, ra, be);
    end
    run_access(1'b1, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_0000, st, la, lv, ld, ra, be, wd, we, stb, lvc);
    checks++;
    if (ld !== 32'h00000080 || lv !== 1'b1) begin
      errors++;
      $display("FAIL lbu_zeroext got data=%h lv=%b want 00000080 1", ld, lv);
    end
    run_access(1'b1, 3'b001, 32'h102, 32'h0, 0, 32'h8001_7FFF, st, la, lv, ld, ra, be, wd, we, stb, lvc);
    checks++;
    if (ld !== 32'hFFFF8001) begin
      errors++;
      $display("FAIL lh_signext got %h want ffff8001", ld);
    end
  endtask

  task automatic test_sh_stall();
    int st, lvc; logic la, lv, we, stb; logic [31:0] ld, ra, wd; logic [3:0] be;
    run_access(1'b0, 3'b001, 32'h202, 32'h0000ABCD, 3, 32'h0, st, la, lv, ld, ra, be, wd, we, stb, lvc);
    checks++;
    if (ra !== 32'h200 || be !== 4'b1100 || wd !== 32'hABCDABCD || we !== 1'b1) begin
      errors++;
      $display("FAIL sh_bus got addr=%h be=%b wd=%h we=%b want 00000200 1100 abcdabcd 1", ra, be, wd, we);
    end
    checks++;
    if (stb !== 1'b1) begin
      errors++;
      $display("FAIL sh_stable got %b want 1", stb);
    end
    checks++;
    if (st != 5 || lv !== 1'b0) begin
      errors++;
      $display("FAIL sh_stall got stall=%0d lv=%b want 5 0", st, lv);
    end
    run_access(1'b0, 3'b010, 32'h204, 32'h89ABCDEF, 0, 32'h0, st, la, lv, ld, ra, be, wd, we, stb, lvc);
    checks++;
    if (be !== 4'b1111 || wd !== 32'h89ABCDEF || st != 2) begin
      errors++;
      $display("FAIL sw_bus got be=%b wd=%h stall=%0d want 1111 89abcdef 2", be, wd, st);
    end
  endtask

  task automatic test_misaligned();
    logic req_seen = 1'b0;
    mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h101;
    @(negedge clk);
    checks++;
    if (misaligned_exc !== 1'b1 || exc_addr !== 32'h101 || lsu_stall !== 1'b0) begin
      errors++;
      $display("FAIL mis_lw got exc=%b ea=%h stall=%b want 1 00000101 0", misaligned_exc, exc_addr, lsu_stall);
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b001; addr = 32'h203;
    @(negedge clk);
    checks++;
    if (misaligned_exc !== 1'b1 || exc_addr !== 32'h203 || lsu_stall !== 1'b0) begin
      errors++;
      $display("FAIL mis_sh got exc=%b ea=%h stall=%b want 1 00000203 0", misaligned_exc, exc_addr, lsu_stall);
    end
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dmem_req || misaligned_exc || lsu_stall) req_seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (req_seen !== 1'b0) begin
      errors++;
      $display("FAIL mis_no_access got activity=%b want 0", req_seen);
    end
  endtask

  task automatic test_ignored();
    logic [2:0] f3s [3] = '{3'b010, 3'b011, 3'b100};
    logic [1:0] rws [3] = '{2'b11, 2'b10, 2'b01};
    for (int i = 0; i < 3; i++) begin
      logic act = 1'b0;
      mem_valid = 1'b1; {mem_read, mem_write} = rws[i]; funct3 = f3s[i]; addr = 32'h101;
      @(negedge clk);
      if (lsu_stall || misaligned_exc) act = 1'b1;
      @(posedge clk); #1;
      mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      if (dmem_req || lsu_stall) act = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (act !== 1'b0) begin
        errors++;
        $display("FAIL ignored_op%0d got activity=%b want 0", i, act);
      end
    end
  endtask

  task automatic test_reset_mid();
    mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h400;
    @(posedge clk); #1;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0; mem_valid = 1'b0; mem_read = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (lsu_stall !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_wait got stall=%b req=%b want 1 0", lsu_stall, dmem_req);
    end
    @(posedge clk); #1;
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || lsu_stall !== 1'b0 || load_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle got req=%b stall=%b lv=%b want 0 0 0", dmem_req, lsu_stall, load_valid);
    end
    @(posedge clk); #1;
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    @(negedge clk);
    checks++;
    if (load_valid !== 1'b0 || load_data !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_late_rvalid got lv=%b data=%h want 0 00000000", load_valid, load_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int st, lvc; logic la, lv, we, stb; logic [31:0] ld, ra, wd; logic [3:0] be;
    run_access(1'b0, 3'b000, 32'h300, 32'h12345678, 0, 32'h0, st, la, lv, ld, ra, be, wd, we, stb, lvc);
    checks++;
    if (be !== 4'b0001 || wd !== 32'h78787878 || ra !== 32'h300 || lv !== 1'b0) begin
      errors++;
      $display("FAIL b2b_sb got be=%b wd=%h addr=%h lv=%b want 0001 78787878 00000300 0", be, wd, ra, lv);
    end
    run_access(1'b1, 3'b101, 32'h302, 32'h0, 0, 32'hBEEF1234, st, la, lv, ld, ra, be, wd, we, stb, lvc);
    checks++;
    if (la !== 1'b1 || st != 3) begin
      errors++;
      $display("FAIL b2b_launch got launched=%b stall=%0d want 1 3", la, st);
    end
    checks++;
    if (be !== 4'b1100 || ld !== 32'h0000BEEF || lvc != 3) begin
      errors++;
      $display("FAIL b2b_lhu got be=%b data=%h cycle=%0d want 1100 0000beef 3", be, ld, lvc);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh_stall();
    test_misaligned();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
